// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute stage: widths and opcode encodings.
package alu_exec_stage_pkg;

    localparam int XLEN     = 32;
    localparam int TAGW     = 5;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU core: one shared adder serves ADD/SUB/SLT/SLTU,
// shifts use the low shift-amount bits of operand B.
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_o,
    output logic                carry_o,
    output logic                zero_o,
    output logic                illegal_o
);

    localparam int SHW = $clog2(XLEN);

    logic            isSub;
    logic [XLEN-1:0] addB;
    logic [XLEN:0]   sum;
    logic [SHW-1:0]  shamt;
    logic            lessSigned;

    assign isSub = (op_i == ALU_SUB) || (op_i == ALU_SLT) || (op_i == ALU_SLTU);
    assign addB  = isSub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, addB} + {{XLEN{1'b0}}, isSub};
    assign shamt = b_i[SHW-1:0];

    // With equal signs the difference cannot overflow, so its sign decides.
    assign lessSigned = (a_i[XLEN-1] != b_i[XLEN-1]) ? a_i[XLEN-1] : sum[XLEN-1];

    always_comb begin
        result_o  = '0;
        carry_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            ALU_ADD, ALU_SUB: begin
                result_o = sum[XLEN-1:0];
                carry_o  = sum[XLEN];
            end
            ALU_SLT: begin
                result_o = {{(XLEN-1){1'b0}}, lessSigned};
                carry_o  = sum[XLEN];
            end
            ALU_SLTU: begin
                result_o = {{(XLEN-1){1'b0}}, ~sum[XLEN]};
                carry_o  = sum[XLEN];
            end
            ALU_SLL: result_o = a_i << shamt;
            ALU_SRL: result_o = a_i >> shamt;
            ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_AND: result_o = a_i & b_i;
            default: illegal_o = 1'b1;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready input, registered result in M, with a
// one-entry skid register S so in_ready never depends on out_ready.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [XLEN-1:0]     in_a,
    input  logic [XLEN-1:0]     in_b,
    input  logic [TAGW-1:0]     in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic                out_carry,
    output logic                out_zero,
    output logic                out_illegal,
    output logic [TAGW-1:0]     out_tag
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            carry;
        logic            zero;
        logic            illegal;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t newEntry;
    entry_t mData_q, mData_d;
    entry_t sData_q, sData_d;
    logic   mValid_q, mValid_d;
    logic   sValid_q, sValid_d;
    logic   accept;
    logic   pop;

    alu_core #(.XLEN(XLEN)) u_core (
        .op_i      (in_op),
        .a_i       (in_a),
        .b_i       (in_b),
        .result_o  (newEntry.result),
        .carry_o   (newEntry.carry),
        .zero_o    (newEntry.zero),
        .illegal_o (newEntry.illegal)
    );
    assign newEntry.tag = in_tag;

    assign in_ready = ~sValid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = mValid_q && out_ready;

    // M is refilled from S first to keep FIFO order; new ops go to S whenever S is or stays occupied.
    always_comb begin
        mData_d  = mData_q;
        sData_d  = sData_q;
        mValid_d = mValid_q;
        sValid_d = sValid_q;
        if (flush) begin
            mValid_d = 1'b0;
            sValid_d = 1'b0;
        end else if (!mValid_q || pop) begin
            if (sValid_q) begin
                mData_d  = sData_q;
                mValid_d = 1'b1;
                sValid_d = accept;
                if (accept) sData_d = newEntry;
            end else begin
                mValid_d = accept;
                if (accept) mData_d = newEntry;
            end
        end else if (accept) begin
            sData_d  = newEntry;
            sValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mData_q  <= '0;
            sData_q  <= '0;
            mValid_q <= 1'b0;
            sValid_q <= 1'b0;
        end else begin
            mData_q  <= mData_d;
            sData_q  <= sData_d;
            mValid_q <= mValid_d;
            sValid_q <= sValid_d;
        end
    end

    assign out_valid   = mValid_q;
    assign out_result  = mData_q.result;
    assign out_carry   = mData_q.carry;
    assign out_zero    = mData_q.zero;
    assign out_illegal = mData_q.illegal;
    assign out_tag     = mData_q.tag;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage that sits directly downstream of the instruction decoder and wraps the 32-bit ALU datapath.
- Accepts one decoded ALU operation per cycle on a valid/ready handshake.
- Computes the result with a combinational ALU core and registers it, together with its flags and tag, into an output stage.
- A one-entry skid buffer absorbs writeback backpressure without a combinational ready path from output to input.

Parameters:
- XLEN, 32, operand and result width; the design is verified only at 32.
- TAGW, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush; drops all held and incoming operations
- in_valid  in  1  decoder presents an operation
- in_ready  out  1  stage can accept an operation this cycle
- in_op  in  4  ALU opcode, encoded per alu_defs
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B (shift amount is in_b[4:0])
- in_tag  in  TAGW  sideband tag, passed through unchanged
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes the result
- out_result  out  XLEN  ALU result
- out_carry  out  1  carry out of the 32-bit adder (ADD/SUB/SLT/SLTU only, else 0)
- out_zero  out  1  out_result == 0
- out_illegal  out  1  opcode was not a defined encoding
- out_tag  out  TAGW  tag of the presented result

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10-15 are illegal.
- An illegal opcode gives result 0, illegal=1, carry=0. It still flows through the stage like any other operation.
- SUB is computed as a + ~b + 1. carry=1 means no borrow.
- SLT/SLTU return 0 or 1 in bit 0. Their carry is the carry of the internal subtract.
- Shifts use in_b[4:0] only; in_b[31:5] is ignored. SRA replicates a[31].
- Storage: a main output register (M) and a skid register (S), each with its own valid bit.
- in_ready is registered and equals !S.valid. It has no combinational dependency on out_ready.
- An operation is accepted when in_valid && in_ready on a rising edge.
- Latency: an operation accepted at edge N is presented at out_valid after edge N when M was empty or drained at edge N. Latency is exactly 1 cycle with no backpressure.
- Throughput is 1 operation per cycle while out_ready=1.
- Per-edge update, let pop = M.valid && out_ready:
  - accept && (!M.valid || pop): M loads the new op; if S.valid, S loads the new op instead and M loads from S (see next rule).
  - S.valid && pop: M loads S contents, S is cleared; a simultaneous accept loads into S.
  - accept && M.valid && !pop: the op goes into S.
  - pop && no replacement: M.valid is cleared.
- Ordering is strictly FIFO. No operation is ever dropped or duplicated except by flush or reset.
- Outputs (result, carry, zero, illegal, tag) come from M and hold stable while out_valid && !out_ready.
- flush=1: M.valid and S.valid clear at the next edge, and any in_valid in that cycle is not accepted. in_ready reads 1 the cycle after.
- flush has priority over accept and pop.
- Reset (asynchronous, mid-operation allowed):
  - out_valid=0, in_ready=1.
  - out_result, out_tag, out_carry, out_zero and out_illegal all 0.
  - Both valid bits 0, so in-flight operations are discarded.
- Data registers need not be cleared on flush; the valid bits gate everything.

Decomposition:
- Shared include alu_defs.vh holds the opcode constants ALU_ADD..ALU_AND, ALU_OP_W=4 and XLEN default 32.
- One combinational sub-module, alu_core: op, a, b in; result, carry, zero, illegal out.
  - Instantiates the existing 32-bit adder for ADD/SUB/SLT/SLTU.
  - Instantiates the existing decoder/shifter pair for SLL/SRL; SRA is derived by sign-fill.
- alu_exec_stage contains only the handshake, the M/S registers and flush/reset logic.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x1, tag=3, out_ready=1 -> one cycle later out_result=0, carry=1, zero=1, tag=3.
- SUB a=5, b=7 -> result=0xFFFFFFFE, carry=0. SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with the same operands -> 0. SRA a=0x80000000, b=0x3F -> 0xFFFFFFFF.
- Backpressure: out_ready=0 while issuing tags 1, 2, 3 on consecutive cycles.
  - Tag 1 sits in M, tag 2 in S, in_ready=0, and tag 3 is held by the source.
  - Raising out_ready yields tags 1, 2, 3 in order with no gaps after the first.
- Streaming: 100 random ops with out_ready=1 throughout -> one result per cycle, each matching the reference model, in_ready constantly 1.
- Illegal op 0xF with a=0x1234 -> result=0, illegal=1, zero=1, carry=0.
- Flush/reset: assert flush with M and S full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed tags never appear.
  - Repeat with rst_n pulsed low mid-stream -> same outcome, asynchronously.
